// File: rtl/countdown_pkg.sv
// countdown_pkg
// Shared type definitions for the countdown_timer block.
//   cd_state_e : controller state (IDLE, RUN, PAUSED)
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } cd_state_e;

endpackage

// File: rtl/countdown_prescaler.sv
// countdown_prescaler
// Divides the clock into decrement opportunities for countdown_timer.
// The internal counter walks 0..PRESCALE-1 while en is high and flags the
// last phase combinationally so the parent can register the resulting tick.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   en       : advance the prescaler this cycle (low = freeze phase)
//   clr      : return the phase to 0 (wins over en)
//   tick_due : a tick falls on the coming edge (equals en when PRESCALE = 1)
module countdown_prescaler
    import countdown_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick_due
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] phase_reg;
    logic          at_last;

    assign at_last  = (phase_reg == LAST);
    // With no division every enabled cycle is a tick.
    assign tick_due = en && ((PRESCALE == 1) || at_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= '0;
        end else if (clr) begin
            phase_reg <= '0;
        end else if (en) begin
            phase_reg <= at_last ? '0 : phase_reg + CW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer
// Loadable, prescaled down-counter with pause, abort and optional
// auto-reload. Do-while semantics: at least one tick elapses before done,
// even for a load value of 0. All outputs are registered.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : load load_val and (re)start counting
//   load_val    : start value, captured on start
//   pause       : level-sensitive freeze while running
//   abort       : cancel, clear count, return to IDLE
//   auto_reload : on done, reload the captured value and keep running
//   count       : current count
//   busy        : high in RUN or PAUSED
//   tick        : one-cycle pulse on each decrement event
//   done        : one-cycle pulse when count reaches 0
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    cd_state_e        state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             busy_reg, busy_next;
    logic             tick_reg, tick_next;
    logic             done_reg, done_next;

    logic             presc_en;
    logic             presc_clr;
    logic             tick_due;
    logic [WIDTH-1:0] count_dec;

    // The prescaler only advances on cycles that actually count: abort and
    // start reset its phase instead, and pause freezes it.
    assign presc_en  = (state_reg != IDLE) && !pause && !abort && !start;
    assign presc_clr = abort || start;

    countdown_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (presc_en),
        .clr      (presc_clr),
        .tick_due (tick_due)
    );

    // Saturating decrement: a zero load stays at zero rather than wrapping.
    assign count_dec = (count_reg == '0) ? '0 : count_reg - WIDTH'(1);

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        tick_next   = 1'b0;
        done_next   = 1'b0;

        if (abort) begin
            state_next = IDLE;
            count_next = '0;
        end else if (start) begin
            state_next  = RUN;
            count_next  = load_val;
            reload_next = load_val;
        end else begin
            unique case (state_reg)
                RUN, PAUSED: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else begin
                        // Leaving PAUSED counts on the same edge so pause
                        // cycles add exactly one cycle each to the latency.
                        state_next = RUN;
                        if (tick_due) begin
                            tick_next  = 1'b1;
                            count_next = count_dec;
                            if (count_dec == '0) begin
                                done_next = 1'b1;
                                if (auto_reload) begin
                                    count_next = reload_reg;
                                end else begin
                                    state_next = IDLE;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            reload_reg <= '0;
            busy_reg   <= 1'b0;
            tick_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            reload_reg <= reload_next;
            busy_reg   <= busy_next;
            tick_reg   <= tick_next;
            done_reg   <= done_next;
        end
    end

    assign count = count_reg;
    assign busy  = busy_reg;
    assign tick  = tick_reg;
    assign done  = done_reg;

endmodule
